mem_request_arbiter: RTL and testbench

Round-robin arbiter that shares one data-memory channel between `NUM_REQUESTERS` load/store units. It serialises read and write requests from the requesters onto the single channel's valid/ready handshake. It returns read data and completion to the winning requester, then rotates priority. It sits between the per-thread LSUs of a core and one external data-memory channel.

---
 rtl/mem_request_arbiter_if.sv | 47 ++++
 rtl/mem_request_arbiter.sv | 177 +++++++++++++++++
 tb/tb_mem_request_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_request_arbiter_if.sv
// mem_request_arbiter_if
//   Bundles the per-requester LSU request/response signals and the shared
//   data-memory channel handshake used by mem_request_arbiter.
// Modports:
//   master - arbiter side: consumes requester valids/addresses/write data and
//            memory ready/read data; drives requester readies/read data and
//            the memory channel request.
//   slave  - environment side (LSUs + data memory): the mirror of master.
interface mem_request_arbiter_if #(
  parameter int unsigned ADDR_BITS      = 8,
  parameter int unsigned DATA_BITS      = 8,
  parameter int unsigned NUM_REQUESTERS = 4
);
  // Requester side
  logic [NUM_REQUESTERS-1:0]                req_read_valid;
  logic [NUM_REQUESTERS-1:0][ADDR_BITS-1:0] req_read_address;
  logic [NUM_REQUESTERS-1:0]                req_read_ready;
  logic [NUM_REQUESTERS-1:0][DATA_BITS-1:0] req_read_data;
  logic [NUM_REQUESTERS-1:0]                req_write_valid;
  logic [NUM_REQUESTERS-1:0][ADDR_BITS-1:0] req_write_address;
  logic [NUM_REQUESTERS-1:0][DATA_BITS-1:0] req_write_data;
  logic [NUM_REQUESTERS-1:0]                req_write_ready;

  // Shared memory channel
  logic                 mem_read_valid;
  logic [ADDR_BITS-1:0] mem_read_address;
  logic                 mem_read_ready;
  logic [DATA_BITS-1:0] mem_read_data;
  logic                 mem_write_valid;
  logic [ADDR_BITS-1:0] mem_write_address;
  logic [DATA_BITS-1:0] mem_write_data;
  logic                 mem_write_ready;

  modport master (
    input  req_read_valid, req_read_address, req_write_valid, req_write_address,
           req_write_data, mem_read_ready, mem_read_data, mem_write_ready,
    output req_read_ready, req_read_data, req_write_ready, mem_read_valid,
           mem_read_address, mem_write_valid, mem_write_address, mem_write_data
  );

  modport slave (
    output req_read_valid, req_read_address, req_write_valid, req_write_address,
           req_write_data, mem_read_ready, mem_read_data, mem_write_ready,
    input  req_read_ready, req_read_data, req_write_ready, mem_read_valid,
           mem_read_address, mem_write_valid, mem_write_address, mem_write_data
  );
endinterface

// File: rtl/mem_request_arbiter.sv
// mem_request_arbiter
//   Round-robin arbiter sharing one data-memory channel between
//   NUM_REQUESTERS load/store units. One transaction is in flight at a time;
//   read wins over write within a requester; priority rotates past the winner
//   after each completed or discarded transaction. All outputs are registered.
// Ports:
//   i_clk      - clock, rising edge
//   i_reset    - asynchronous active-high reset
//   io_bus     - requester and memory channel signals (master modport)
//   o_busy     - high whenever the FSM is not idle
//   o_grant_id - index of the current or most recent winner
module mem_request_arbiter #(
  parameter int unsigned ADDR_BITS      = 8,
  parameter int unsigned DATA_BITS      = 8,
  parameter int unsigned NUM_REQUESTERS = 4
) (
  input  logic                              i_clk,
  input  logic                              i_reset,
  mem_request_arbiter_if.master             io_bus,
  output logic                              o_busy,
  output logic [$clog2(NUM_REQUESTERS)-1:0] o_grant_id
);

  localparam int unsigned IdBits = $clog2(NUM_REQUESTERS);

  typedef enum logic [1:0] {StIdle, StReadWait, StWriteWait, StRelay} state_e;

  state_e                                   r_state, w_state_next;
  logic [IdBits-1:0]                        r_rr_ptr, w_rr_ptr_next;
  logic [IdBits-1:0]                        r_grant_id, w_grant_id_next;
  logic                                     r_mem_read_valid, w_mem_read_valid_next;
  logic                                     r_mem_write_valid, w_mem_write_valid_next;
  logic [ADDR_BITS-1:0]                     r_mem_read_address, w_mem_read_address_next;
  logic [ADDR_BITS-1:0]                     r_mem_write_address, w_mem_write_address_next;
  logic [DATA_BITS-1:0]                     r_mem_write_data, w_mem_write_data_next;
  logic [NUM_REQUESTERS-1:0]                r_req_read_ready, w_req_read_ready_next;
  logic [NUM_REQUESTERS-1:0]                r_req_write_ready, w_req_write_ready_next;
  logic [NUM_REQUESTERS-1:0][DATA_BITS-1:0] r_req_read_data, w_req_read_data_next;

  logic              w_found;
  logic [IdBits-1:0] w_win;
  logic [IdBits-1:0] w_scan;
  logic [IdBits-1:0] w_ptr_after;
  logic              w_relay_done;

  // Round-robin scan starting at r_rr_ptr; first requester with any valid wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_scan  = '0;
    for (int unsigned i = 0; i < NUM_REQUESTERS; i++) begin
      w_scan = IdBits'((32'(r_rr_ptr) + i) % NUM_REQUESTERS);
      if (!w_found && (io_bus.req_read_valid[w_scan] || io_bus.req_write_valid[w_scan])) begin
        w_found = 1'b1;
        w_win   = w_scan;
      end
    end
  end

  assign w_ptr_after = (r_grant_id == IdBits'(NUM_REQUESTERS - 1)) ? '0
                                                                    : r_grant_id + IdBits'(1);

  // The asserted ready bit tells RELAY which of the winner's valids to watch.
  assign w_relay_done = r_req_read_ready[r_grant_id] ? !io_bus.req_read_valid[r_grant_id]
                                                     : !io_bus.req_write_valid[r_grant_id];

  always_comb begin
    w_state_next             = r_state;
    w_rr_ptr_next            = r_rr_ptr;
    w_grant_id_next          = r_grant_id;
    w_mem_read_valid_next    = r_mem_read_valid;
    w_mem_write_valid_next   = r_mem_write_valid;
    w_mem_read_address_next  = r_mem_read_address;
    w_mem_write_address_next = r_mem_write_address;
    w_mem_write_data_next    = r_mem_write_data;
    w_req_read_ready_next    = r_req_read_ready;
    w_req_write_ready_next   = r_req_write_ready;
    w_req_read_data_next     = r_req_read_data;

    unique case (r_state)
      StIdle: begin
        if (w_found) begin
          w_grant_id_next = w_win;
          if (io_bus.req_read_valid[w_win]) begin
            w_mem_read_valid_next   = 1'b1;
            w_mem_read_address_next = io_bus.req_read_address[w_win];
            w_state_next            = StReadWait;
          end else begin
            w_mem_write_valid_next   = 1'b1;
            w_mem_write_address_next = io_bus.req_write_address[w_win];
            w_mem_write_data_next    = io_bus.req_write_data[w_win];
            w_state_next             = StWriteWait;
          end
        end
      end

      StReadWait: begin
        if (io_bus.mem_read_ready) begin
          w_mem_read_valid_next = 1'b0;
          if (io_bus.req_read_valid[r_grant_id]) begin
            w_req_read_data_next[r_grant_id]  = io_bus.mem_read_data;
            w_req_read_ready_next[r_grant_id] = 1'b1;
            w_state_next                      = StRelay;
          end else begin
            // Requester gave up while waiting: drop the data, still rotate.
            w_rr_ptr_next = w_ptr_after;
            w_state_next  = StIdle;
          end
        end
      end

      StWriteWait: begin
        if (io_bus.mem_write_ready) begin
          w_mem_write_valid_next = 1'b0;
          if (io_bus.req_write_valid[r_grant_id]) begin
            w_req_write_ready_next[r_grant_id] = 1'b1;
            w_state_next                       = StRelay;
          end else begin
            w_rr_ptr_next = w_ptr_after;
            w_state_next  = StIdle;
          end
        end
      end

      StRelay: begin
        if (w_relay_done) begin
          w_req_read_ready_next  = '0;
          w_req_write_ready_next = '0;
          w_rr_ptr_next          = w_ptr_after;
          w_state_next           = StIdle;
        end
      end

      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state             <= StIdle;
      r_rr_ptr            <= '0;
      r_grant_id          <= '0;
      r_mem_read_valid    <= 1'b0;
      r_mem_write_valid   <= 1'b0;
      r_mem_read_address  <= '0;
      r_mem_write_address <= '0;
      r_mem_write_data    <= '0;
      r_req_read_ready    <= '0;
      r_req_write_ready   <= '0;
      r_req_read_data     <= '0;
    end else begin
      r_state             <= w_state_next;
      r_rr_ptr            <= w_rr_ptr_next;
      r_grant_id          <= w_grant_id_next;
      r_mem_read_valid    <= w_mem_read_valid_next;
      r_mem_write_valid   <= w_mem_write_valid_next;
      r_mem_read_address  <= w_mem_read_address_next;
      r_mem_write_address <= w_mem_write_address_next;
      r_mem_write_data    <= w_mem_write_data_next;
      r_req_read_ready    <= w_req_read_ready_next;
      r_req_write_ready   <= w_req_write_ready_next;
      r_req_read_data     <= w_req_read_data_next;
    end
  end

  assign io_bus.mem_read_valid    = r_mem_read_valid;
  assign io_bus.mem_read_address  = r_mem_read_address;
  assign io_bus.mem_write_valid   = r_mem_write_valid;
  assign io_bus.mem_write_address = r_mem_write_address;
  assign io_bus.mem_write_data    = r_mem_write_data;
  assign io_bus.req_read_ready    = r_req_read_ready;
  assign io_bus.req_read_data     = r_req_read_data;
  assign io_bus.req_write_ready   = r_req_write_ready;
  assign o_busy                   = (r_state != StIdle);
  assign o_grant_id               = r_grant_id;

endmodule

// File: tb/tb_mem_request_arbiter.sv
// tb_mem_request_arbiter
//   Self-checking bench for mem_request_arbiter. A single-threaded tick task
//   models the data memory and the per-requester LSU agents at the falling
//   edge; expected channel grants sit in a scoreboard queue and are popped
//   as the memory accepts each request, expected read data rides with each
//   queued requester operation.
module tb_mem_request_arbiter;
  localparam int unsigned NR = 4;
  localparam int unsigned AB = 8;
  localparam int unsigned DB = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       busy;
  logic [1:0] grant_id;

  always #5 clk = ~clk;

  mem_request_arbiter_if #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_REQUESTERS(NR)) bus ();

  mem_request_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_REQUESTERS(NR)) dut (
    .i_clk     (clk),
    .i_reset   (reset),
    .io_bus    (bus),
    .o_busy    (busy),
    .o_grant_id(grant_id)
  );

  typedef struct packed {logic [7:0] addr; logic [7:0] data;} op_t;
  typedef struct packed {logic [1:0] id; logic wr; logic [7:0] addr; logic [7:0] data;} chan_t;
  typedef struct packed {
    logic [1:0] id; logic wr; logic [7:0] addr; logic [7:0] wdata; logic [7:0] exp_rdata;
  } vec_t;

  op_t        rq [NR][$];
  op_t        wq [NR][$];
  chan_t      chan_q[$];
  logic [NR-1:0] rbusy, wbusy;
  logic [7:0] rexp [NR];
  int         rissue [NR];
  logic [7:0] mem [256];
  int         mem_cnt, mem_lat, cyc, n_done, last_rlat;
  int         n_total, n_bad;
  vec_t       vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic rd(input int id, input logic [7:0] a, input logic [7:0] e);
    op_t op;
    op.addr = a;
    op.data = e;
    rq[id].push_back(op);
  endtask

  task automatic wrq(input int id, input logic [7:0] a, input logic [7:0] d);
    op_t op;
    op.addr = a;
    op.data = d;
    wq[id].push_back(op);
  endtask

  task automatic expect_grant(input int id, input logic w, input logic [7:0] a,
                              input logic [7:0] d);
    chan_t c;
    c.id   = 2'(id);
    c.wr   = w;
    c.addr = a;
    c.data = d;
    chan_q.push_back(c);
  endtask

  task automatic clear_agents();
    for (int i = 0; i < NR; i++) begin
      rq[i].delete();
      wq[i].delete();
    end
    chan_q.delete();
    rbusy = '0;
    wbusy = '0;
    bus.req_read_valid    = '0;
    bus.req_read_address  = '0;
    bus.req_write_valid   = '0;
    bus.req_write_address = '0;
    bus.req_write_data    = '0;
    bus.mem_read_ready    = 1'b0;
    bus.mem_read_data     = '0;
    bus.mem_write_ready   = 1'b0;
    mem_cnt = 0;
  endtask

  task automatic check_reset_outputs(input string p);
    chk({p, "_mem_read_valid"}, 32'(bus.mem_read_valid), 0);
    chk({p, "_mem_write_valid"}, 32'(bus.mem_write_valid), 0);
    chk({p, "_mem_read_address"}, 32'(bus.mem_read_address), 0);
    chk({p, "_mem_write_address"}, 32'(bus.mem_write_address), 0);
    chk({p, "_mem_write_data"}, 32'(bus.mem_write_data), 0);
    chk({p, "_req_read_ready"}, 32'(bus.req_read_ready), 0);
    chk({p, "_req_write_ready"}, 32'(bus.req_write_ready), 0);
    chk({p, "_req_read_data"}, 32'(bus.req_read_data), 0);
    chk({p, "_busy"}, 32'(busy), 0);
    chk({p, "_grant_id"}, 32'(grant_id), 0);
  endtask

  // One clock: sample at the falling edge, then update memory and LSU agents.
  task automatic tick();
    logic [NR-1:0] rr, wr;
    op_t   op;
    chan_t e;
    @(negedge clk);
    cyc++;
    rr = bus.req_read_ready;
    wr = bus.req_write_ready;
    chk("mem_valid_exclusive", 32'(bus.mem_read_valid & bus.mem_write_valid), 0);
    chk("ready_onehot", 32'($countones({rr, wr}) > 1), 0);

    if (bus.mem_read_ready || bus.mem_write_ready) begin
      bus.mem_read_ready  = 1'b0;
      bus.mem_write_ready = 1'b0;
      mem_cnt = 0;
    end else if (bus.mem_read_valid || bus.mem_write_valid) begin
      if (mem_cnt >= mem_lat) begin
        chk("chan_expected", 32'(chan_q.size() != 0), 1);
        if (chan_q.size() != 0) begin
          e = chan_q.pop_front();
          chk("chan_grant_id", 32'(grant_id), 32'(e.id));
          chk("chan_is_write", 32'(bus.mem_write_valid), 32'(e.wr));
          if (bus.mem_write_valid) begin
            chk("chan_wr_addr", 32'(bus.mem_write_address), 32'(e.addr));
            chk("chan_wr_data", 32'(bus.mem_write_data), 32'(e.data));
            mem[bus.mem_write_address] = bus.mem_write_data;
            bus.mem_write_ready = 1'b1;
          end else begin
            chk("chan_rd_addr", 32'(bus.mem_read_address), 32'(e.addr));
            bus.mem_read_data  = mem[bus.mem_read_address];
            bus.mem_read_ready = 1'b1;
          end
        end
      end else begin
        mem_cnt++;
      end
    end

    for (int i = 0; i < NR; i++) begin
      chk("spurious_rd_ready", 32'(rr[i] & ~rbusy[i]), 0);
      chk("spurious_wr_ready", 32'(wr[i] & ~wbusy[i]), 0);
      if (rr[i] && rbusy[i]) begin
        chk("rd_data", 32'(bus.req_read_data[i]), 32'(rexp[i]));
        last_rlat = cyc - rissue[i];
        bus.req_read_valid[i] = 1'b0;
        rbusy[i] = 1'b0;
        n_done++;
      end
      if (wr[i] && wbusy[i]) begin
        bus.req_write_valid[i] = 1'b0;
        wbusy[i] = 1'b0;
        n_done++;
      end
      if (!rbusy[i] && !rr[i] && rq[i].size() != 0) begin
        op = rq[i].pop_front();
        bus.req_read_valid[i]   = 1'b1;
        bus.req_read_address[i] = op.addr;
        rexp[i]   = op.data;
        rbusy[i]  = 1'b1;
        rissue[i] = cyc;
      end
      if (!wbusy[i] && !wr[i] && wq[i].size() != 0) begin
        op = wq[i].pop_front();
        bus.req_write_valid[i]   = 1'b1;
        bus.req_write_address[i] = op.addr;
        bus.req_write_data[i]    = op.data;
        wbusy[i] = 1'b1;
      end
    end
  endtask

  function automatic bit all_idle();
    bit q_empty;
    q_empty = 1'b1;
    for (int i = 0; i < NR; i++) begin
      if (rq[i].size() != 0 || wq[i].size() != 0) q_empty = 1'b0;
    end
    return q_empty && rbusy == '0 && wbusy == '0 && chan_q.size() == 0 && !busy
           && !bus.mem_read_ready && !bus.mem_write_ready;
  endfunction

  task automatic drain(input string name, input int budget);
    bit done;
    done = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      tick();
      done = all_idle();
    end
    chk({name, "_drained"}, 32'(done), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap, maxgap;
    n_total = 0; n_bad = 0; cyc = 0; n_done = 0; last_rlat = 0; mem_lat = 1;
    for (int a = 0; a < 256; a++) mem[a] = 8'(a) ^ 8'h3C;
    for (int a = 0; a < 4; a++) mem[a] = 8'(a + 1);
    mem[5] = 8'd2;
    clear_agents();

    vecs[0] = '{id: 2'd0, wr: 1'b1, addr: 8'd11,  wdata: 8'd22,  exp_rdata: 8'h00};
    vecs[1] = '{id: 2'd1, wr: 1'b0, addr: 8'd11,  wdata: 8'h00,  exp_rdata: 8'd22};
    vecs[2] = '{id: 2'd3, wr: 1'b1, addr: 8'd200, wdata: 8'hA5,  exp_rdata: 8'h00};
    vecs[3] = '{id: 2'd3, wr: 1'b0, addr: 8'd200, wdata: 8'h00,  exp_rdata: 8'hA5};
    vecs[4] = '{id: 2'd2, wr: 1'b0, addr: 8'd7,   wdata: 8'h00,  exp_rdata: 8'h3B};
    vecs[5] = '{id: 2'd1, wr: 1'b1, addr: 8'd7,   wdata: 8'h5E,  exp_rdata: 8'h00};
    vecs[6] = '{id: 2'd0, wr: 1'b0, addr: 8'd7,   wdata: 8'h00,  exp_rdata: 8'h5E};
    vecs[7] = '{id: 2'd2, wr: 1'b0, addr: 8'd255, wdata: 8'h00,  exp_rdata: 8'hC3};

    // Power-on reset
    tick();
    tick();
    check_reset_outputs("por");
    reset = 1'b0;

    // Single read: requester 2, addr 5, 1-cycle memory
    rd(2, 8'd5, 8'd2);
    expect_grant(2, 1'b0, 8'd5, 8'h00);
    drain("single_read", 30);
    chk("single_read_latency", last_rlat, 3);

    // Pointer now 3: requester 3 must beat requester 0
    rd(0, 8'd1, 8'd2);
    rd(3, 8'd2, 8'd3);
    expect_grant(3, 1'b0, 8'd2, 8'h00);
    expect_grant(0, 1'b0, 8'd1, 8'h00);
    drain("ptr_after_read", 40);

    // Table of isolated single transactions
    for (int k = 0; k < 8; k++) begin
      if (vecs[k].wr) wrq(int'(vecs[k].id), vecs[k].addr, vecs[k].wdata);
      else rd(int'(vecs[k].id), vecs[k].addr, vecs[k].exp_rdata);
      expect_grant(int'(vecs[k].id), vecs[k].wr, vecs[k].addr, vecs[k].wr ? vecs[k].wdata : 8'h00);
      drain($sformatf("vec%0d", k), 30);
    end

    // Contention from reset: all four read at once
    reset = 1'b1;
    clear_agents();
    tick();
    check_reset_outputs("reset2");
    reset = 1'b0;
    for (int i = 0; i < NR; i++) begin
      rd(i, 8'(i), 8'(i + 1));
      expect_grant(i, 1'b0, 8'(i), 8'h00);
    end
    n_done = 0; gap = 0; maxgap = 0;
    for (int k = 0; k < 60 && n_done < 4; k++) begin
      tick();
      if (!busy) gap++;
      else gap = 0;
      if (gap > maxgap) maxgap = gap;
    end
    chk("contention_done", n_done, 4);
    chk("contention_busy_gap_le1", 32'(maxgap <= 1), 1);
    drain("contention", 20);
    for (int i = 0; i < NR; i++) chk("rd_data_retained", 32'(bus.req_read_data[i]), i + 1);

    // Fairness: requester 1 back-to-back vs requester 3 holding
    rd(1, 8'd20, 8'h28); rd(1, 8'd21, 8'h29); rd(1, 8'd22, 8'h2A);
    rd(3, 8'd40, 8'h14); rd(3, 8'd41, 8'h15);
    expect_grant(1, 1'b0, 8'd20, 8'h00);
    expect_grant(3, 1'b0, 8'd40, 8'h00);
    expect_grant(1, 1'b0, 8'd21, 8'h00);
    expect_grant(3, 1'b0, 8'd41, 8'h00);
    expect_grant(1, 1'b0, 8'd22, 8'h00);
    drain("fairness", 100);

    // Read/write priority within requester 1
    rd(1, 8'd4, 8'h38);
    wrq(1, 8'd9, 8'h99);
    expect_grant(1, 1'b0, 8'd4, 8'h00);
    expect_grant(1, 1'b1, 8'd9, 8'h99);
    drain("rw_priority", 40);

    // Abort: requester 0 drops its read during READ_WAIT
    mem_lat = 3;
    rd(0, 8'd10, 8'h00);
    expect_grant(0, 1'b0, 8'd10, 8'h00);
    for (int k = 0; k < 10 && !bus.mem_read_valid; k++) tick();
    chk("abort_granted", 32'(bus.mem_read_valid), 1);
    bus.req_read_valid[0] = 1'b0;
    rbusy[0] = 1'b0;
    drain("abort", 30);
    mem_lat = 1;
    rd(0, 8'd12, 8'h30);
    rd(1, 8'd13, 8'h31);
    expect_grant(1, 1'b0, 8'd13, 8'h00);
    expect_grant(0, 1'b0, 8'd12, 8'h00);
    drain("ptr_after_abort", 40);

    // Asynchronous reset during WRITE_WAIT
    mem_lat = 5;
    wrq(2, 8'd30, 8'h77);
    for (int k = 0; k < 10 && !bus.mem_write_valid; k++) tick();
    chk("wr_granted_before_reset", 32'(bus.mem_write_valid), 1);
    #2 reset = 1'b1;
    #1 check_reset_outputs("async_reset");
    clear_agents();
    tick();
    tick();
    reset = 1'b0;
    mem_lat = 1;
    repeat (5) tick();
    rd(0, 8'd1, 8'd2);
    rd(3, 8'd3, 8'd4);
    expect_grant(0, 1'b0, 8'd1, 8'h00);
    expect_grant(3, 1'b0, 8'd3, 8'h00);
    drain("post_reset", 40);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
